// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction fetch stage. Owns the PC, issues word reads to a
//             1-cycle-latency instruction ROM, buffers returned words in a
//             2-entry FIFO and presents {instr, pc, pc+4} to decode using a
//             valid/ready handshake. Accepts PC redirects from downstream.
//  Ports    : clk, rst_n (async, active-low)
//             imem_req / imem_addr / imem_rdata : ROM read interface
//             redirect_valid / redirect_pc      : downstream PC redirect
//             id_ready / id_valid / id_instr / id_pc / id_pc_plus4 : decode
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4
);

   localparam logic STATE_BOOT = 1'b0;
   localparam logic STATE_RUN  = 1'b1;

   logic        state;
   logic        next_state;
   logic [31:0] pc;
   logic [31:0] req_pc;
   logic [1:0]  count;
   logic        inflight;
   logic        epoch;
   logic        tag;
   logic        pop;
   logic        push;
   logic [2:0]  occupancy;
   logic [31:0] push_pc4;
   logic        unused_redirect_lo;

   // FIFO storage: entry 0 is always the head presented to decode.
   logic [31:0] e0_instr, e0_pc, e0_pc4;
   logic [31:0] e1_instr, e1_pc, e1_pc4;

   // Low address bits of the redirect target are forced to zero.
   assign unused_redirect_lo = ^redirect_pc[1:0];

   assign id_valid    = (count != 2'd0) & ~redirect_valid;
   assign pop         = id_valid & id_ready;
   // Slots already promised (stored + in flight) after this cycle's pop.
   assign occupancy   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
   // A stale response is dropped either by epoch mismatch or by a redirect
   // in the same cycle (which empties the FIFO anyway).
   assign push        = inflight & (tag == epoch) & ~redirect_valid;
   assign push_pc4    = req_pc + 32'd4;
   assign imem_addr   = pc;
   assign id_instr    = e0_instr;
   assign id_pc       = e0_pc;
   assign id_pc_plus4 = e0_pc4;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= STATE_BOOT;
      else        state <= next_state;
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      next_state = state;
      case (state)
         STATE_BOOT: next_state = STATE_RUN;
         STATE_RUN:  next_state = STATE_RUN;
         default:    next_state = STATE_BOOT;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      imem_req = 1'b0;
      if (state == STATE_RUN)
         imem_req = ~redirect_valid & (occupancy < 3'(BUF_DEPTH));
   end

   // ---------------- PC, request tracking, epoch ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         req_pc   <= 32'd0;
         inflight <= 1'b0;
         tag      <= 1'b0;
         epoch    <= 1'b0;
      end else begin
         // A redirect suppresses imem_req, so inflight clears on redirect.
         inflight <= imem_req;
         if (redirect_valid) begin
            pc    <= {redirect_pc[31:2], 2'b00};
            epoch <= ~epoch;
         end else if (imem_req) begin
            pc     <= pc + 32'd4;
            req_pc <= pc;
            tag    <= epoch;
         end
      end
   end

   // ---------------- Instruction buffer ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= 2'd0;
         e0_instr <= 32'd0;
         e0_pc    <= 32'd0;
         e0_pc4   <= 32'd0;
         e1_instr <= 32'd0;
         e1_pc    <= 32'd0;
         e1_pc4   <= 32'd0;
      end else if (redirect_valid) begin
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  e0_instr <= imem_rdata;
                  e0_pc    <= req_pc;
                  e0_pc4   <= push_pc4;
               end else begin
                  e1_instr <= imem_rdata;
                  e1_pc    <= req_pc;
                  e1_pc4   <= push_pc4;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               e0_instr <= e1_instr;
               e0_pc    <= e1_pc;
               e0_pc4   <= e1_pc4;
               count    <= count - 2'd1;
            end
            2'b11: begin
               // Count unchanged; new word lands behind whatever remains.
               if (count == 2'd1) begin
                  e0_instr <= imem_rdata;
                  e0_pc    <= req_pc;
                  e0_pc4   <= push_pc4;
               end else begin
                  e0_instr <= e1_instr;
                  e0_pc    <= e1_pc;
                  e0_pc4   <= e1_pc4;
                  e1_instr <= imem_rdata;
                  e1_pc    <= req_pc;
                  e1_pc4   <= push_pc4;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Self-checking bench for fetch_stage. A cycle table drives
//             id_ready / redirect and checks request and valid behaviour;
//             scoreboards of expected PCs check every accepted instruction.
//             A second instance with RESET_PC=FFFF_FFF8 checks PC wrap.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;
   localparam logic [31:0] K = 32'hA5A5_0000;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        imem_req, id_valid;
   logic [31:0] imem_addr, imem_rdata, id_instr, id_pc, id_pc_plus4;

   logic        w_req, w_valid;
   logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc4;

   fetch_stage dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
      .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk(clk), .rst_n(rst_n),
      .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
      .redirect_valid(1'b0), .redirect_pc(32'd0),
      .id_ready(1'b1), .id_valid(w_valid), .id_instr(w_instr),
      .id_pc(w_pc), .id_pc_plus4(w_pc4)
   );

   // ROM models: data = addr ^ K one cycle after a request, junk otherwise.
   always_ff @(posedge clk) begin
      imem_rdata <= imem_req ? (imem_addr ^ K) : 32'hDEAD_BEEF;
      w_rdata    <= w_req    ? (w_addr ^ K)    : 32'hDEAD_BEEF;
   end

   int checks = 0;
   int errors = 0;
   int pops2  = 0;
   logic [31:0] q1[$];
   logic [31:0] q2[$];

   typedef struct {
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        req;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] pc;
   } vec_t;

   vec_t tbl[31];

   function automatic vec_t mk(logic rdy, logic rv, logic [31:0] rpc, logic req,
                               logic [31:0] addr, logic vld, logic [31:0] pc);
      vec_t v;
      v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.req = req;
      v.addr = addr; v.vld = vld; v.pc = pc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic sb1_fill(input logic [31:0] base);
      q1.delete();
      for (int i = 0; i < 64; i++) q1.push_back(base + 32'(4 * i));
   endtask

   task automatic sb2_fill(input logic [31:0] base);
      q2.delete();
      for (int i = 0; i < 64; i++) q2.push_back(base + 32'(4 * i));
   endtask

   task automatic sb_check;
      logic [31:0] e;
      if (id_valid && id_ready) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb1_empty actual=%h required=none", id_pc);
         end else begin
            e = q1.pop_front();
            chk("sb1_pc", id_pc, e);
            chk("sb1_instr", id_instr, e ^ K);
            chk("sb1_pc4", id_pc_plus4, e + 32'd4);
         end
      end
      if (w_valid) begin
         pops2++;
         if (q2.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb2_empty actual=%h required=none", w_pc);
         end else begin
            e = q2.pop_front();
            chk("sb2_pc", w_pc, e);
            chk("sb2_instr", w_instr, e ^ K);
            chk("sb2_pc4", w_pc4, e + 32'd4);
         end
      end
   endtask

   // One clock cycle: drive inputs shortly after the edge, check mid-cycle.
   task automatic cyc(input logic r, input logic rv, input logic [31:0] rp);
      @(posedge clk);
      #2;
      rst_n          = 1'b1;
      id_ready       = r;
      redirect_valid = rv;
      redirect_pc    = rp;
      if (rv) sb1_fill({rp[31:2], 2'b00});
      #3;
      sb_check();
   endtask

   initial begin
      //              rdy rv  rpc          req addr         vld pc
      tbl[0]  = mk(1, 0, 32'h0,   0, 32'h0,   0, 32'h0);
      tbl[1]  = mk(1, 0, 32'h0,   1, 32'h0,   0, 32'h0);
      tbl[2]  = mk(1, 0, 32'h0,   1, 32'h4,   0, 32'h0);
      tbl[3]  = mk(1, 0, 32'h0,   1, 32'h8,   1, 32'h0);
      tbl[4]  = mk(1, 0, 32'h0,   1, 32'hC,   1, 32'h4);
      tbl[5]  = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h8);
      tbl[6]  = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h8);
      tbl[7]  = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h8);
      tbl[8]  = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h8);
      tbl[9]  = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h8);
      tbl[10] = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h8);
      tbl[11] = mk(1, 0, 32'h0,   1, 32'h10,  1, 32'h8);
      tbl[12] = mk(1, 0, 32'h0,   1, 32'h14,  1, 32'hC);
      tbl[13] = mk(1, 0, 32'h0,   1, 32'h18,  1, 32'h10);
      tbl[14] = mk(1, 1, 32'h100, 0, 32'h0,   0, 32'h0);
      tbl[15] = mk(1, 0, 32'h0,   1, 32'h100, 0, 32'h0);
      tbl[16] = mk(1, 0, 32'h0,   1, 32'h104, 0, 32'h0);
      tbl[17] = mk(1, 0, 32'h0,   1, 32'h108, 1, 32'h100);
      tbl[18] = mk(1, 0, 32'h0,   1, 32'h10C, 1, 32'h104);
      tbl[19] = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h108);
      tbl[20] = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h108);
      tbl[21] = mk(0, 1, 32'h203, 0, 32'h0,   0, 32'h0);
      tbl[22] = mk(1, 0, 32'h0,   1, 32'h200, 0, 32'h0);
      tbl[23] = mk(1, 0, 32'h0,   1, 32'h204, 0, 32'h0);
      tbl[24] = mk(1, 0, 32'h0,   1, 32'h208, 1, 32'h200);
      tbl[25] = mk(1, 0, 32'h0,   1, 32'h20C, 1, 32'h204);
      tbl[26] = mk(1, 1, 32'h300, 0, 32'h0,   0, 32'h0);
      tbl[27] = mk(1, 1, 32'h400, 0, 32'h0,   0, 32'h0);
      tbl[28] = mk(1, 0, 32'h0,   1, 32'h400, 0, 32'h0);
      tbl[29] = mk(1, 0, 32'h0,   1, 32'h404, 0, 32'h0);
      tbl[30] = mk(1, 0, 32'h0,   1, 32'h408, 1, 32'h400);

      rst_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
      #12;
      chk("rst_req",   {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, id_valid}, 32'd0);
      chk("rst_instr", id_instr, 32'd0);
      chk("rst_pc",    id_pc, 32'd0);
      chk("rst_pc4",   id_pc_plus4, 32'd0);
      chk("rst_w_addr", w_addr, 32'hFFFF_FFF8);

      for (int pass = 0; pass < 2; pass++) begin
         sb1_fill(32'h0);
         sb2_fill(32'hFFFF_FFF8);
         for (int i = 0; i < 31; i++) begin
            cyc(tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
            chk($sformatf("p%0d_r%0d_req", pass, i), {31'd0, imem_req}, {31'd0, tbl[i].req});
            if (tbl[i].req)
               chk($sformatf("p%0d_r%0d_addr", pass, i), imem_addr, tbl[i].addr);
            chk($sformatf("p%0d_r%0d_valid", pass, i), {31'd0, id_valid}, {31'd0, tbl[i].vld});
            if (tbl[i].vld)
               chk($sformatf("p%0d_r%0d_pc", pass, i), id_pc, tbl[i].pc);
         end

         if (pass == 0) begin
            // Asynchronous reset pulsed between edges while streaming.
            @(posedge clk);
            #2;
            id_ready = 1'b1;
            #2;
            chk("pre_rst_valid", {31'd0, id_valid}, 32'd1);
            chk("pre_rst_req",   {31'd0, imem_req}, 32'd1);
            rst_n = 1'b0;
            #1;
            chk("async_rst_req",   {31'd0, imem_req}, 32'd0);
            chk("async_rst_valid", {31'd0, id_valid}, 32'd0);
            chk("async_rst_pc",    id_pc, 32'd0);
            chk("async_rst_wvalid", {31'd0, w_valid}, 32'd0);
            repeat (2) @(posedge clk);
         end
      end

      checks++;
      if (pops2 < 20) begin
         errors++;
         $display("FAIL wrap_stream_pops actual=%0d required>=20", pops2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
